// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-file write port among writeback sources
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         x0_drop,
    output logic [NUM_REQ*CNT_W-1:0]     grant_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]   last_ptr;
    logic [ID_W-1:0]   sel;
    logic              found;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W-1:0]  cnt [NUM_REQ];

    // Scan farthest-first so the nearest valid requester after last_ptr wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = ID_W'((int'(last_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready = (found && !stall && !rst) ? NUM_REQ'(1) << sel : '0;
    assign xfer      = |req_ready;
    assign sel_addr  = req_addr[sel*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[sel*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ptr <= ID_W'(NUM_REQ - 1);
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
            x0_drop  <= 1'b0;
        end else begin
            rf_we   <= xfer && sel_addr != '0;
            x0_drop <= xfer && sel_addr == '0;
            if (xfer) begin
                last_ptr <= sel;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                grant_id <= sel;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt[i] <= '0;
            else if (req_ready[i] && cnt[i] != '1)
                cnt[i] <= cnt[i] + 1'b1;
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a scoreboard queue and a decoupled writeback monitor
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  grant_id;
    logic        x0_drop;
    logic [11:0] grant_cnt;

    logic [4:0]  a [3] = '{5'd0, 5'd0, 5'd0};
    logic [31:0] d [3] = '{32'd0, 32'd0, 32'd0};
    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  id;
        logic        drop;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .grant_id(grant_id), .x0_drop(x0_drop), .grant_cnt(grant_cnt)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Entered just after a rising edge; checks ready, queues the expected write, advances one cycle.
    task automatic tick(input logic [2:0] er);
        #1 chk("req_ready", req_ready, er);
        for (int i = 0; i < 3; i++)
            if (er[i]) q.push_back('{a[i] != 0, a[i], d[i], 2'(i), a[i] == 0});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        tick(3'b000);
        tick(3'b000);
        chk("sb_empty", 64'(q.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_id", grant_id, 0);
        chk("rst_drop", x0_drop, 0);
        chk("rst_cnt", grant_cnt, 0);
        chk("rst_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (rf_we || x0_drop)) begin
                if (q.size() == 0) begin
                    chk("unexpected_wb", {rf_we, x0_drop}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_we", rf_we, e.we);
                    chk("wb_waddr", rf_waddr, e.addr);
                    chk("wb_wdata", rf_wdata, e.data);
                    chk("wb_id", grant_id, e.id);
                    chk("wb_drop", x0_drop, e.drop);
                end
            end
        end
    end

    logic [2:0]  pv = '0, pr = '0;
    logic [14:0] pa = '0;
    logic [95:0] pd = '0;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (!rst && pv[i] && !pr[i] && req_valid[i])
                assert (req_addr[i*5 +: 5] == pa[i*5 +: 5] && req_data[i*32 +: 32] == pd[i*32 +: 32])
                else $error("requester %0d changed payload while waiting", i);
        pv <= req_valid;
        pr <= req_ready;
        pa <= req_addr;
        pd <= req_data;
    end

    initial begin
        do_reset();

        // Round-robin over three busy requesters
        a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
        d[0] = 32'h1111_0000; d[1] = 32'h2222_0000; d[2] = 32'h3333_0000;
        req_valid = 3'b111;
        tick(3'b001); tick(3'b010); tick(3'b100);
        tick(3'b001); tick(3'b010); tick(3'b100);
        drain();
        chk("cnt_rr", grant_cnt, {4'd2, 4'd2, 4'd2});

        // Single requester with a write landing one cycle later
        a[1] = 5'd7; d[1] = 32'hDEADBEEF;
        req_valid = 3'b010;
        tick(3'b010);
        req_valid = 3'b000;
        chk("t2_we", rf_we, 1);
        chk("t2_waddr", rf_waddr, 7);
        chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
        chk("t2_id", grant_id, 1);
        drain();

        // x0 destination: handshake completes, write suppressed
        do_reset();
        a[0] = 5'd0; d[0] = 32'h1234;
        req_valid = 3'b001;
        tick(3'b001);
        req_valid = 3'b000;
        chk("t3_we", rf_we, 0);
        chk("t3_drop", x0_drop, 1);
        chk("t3_cnt", grant_cnt, {4'd0, 4'd0, 4'd1});
        tick(3'b000);
        chk("t3_drop_clr", x0_drop, 0);
        drain();

        // Stall raised together with valid; pointer holds at 0
        stall = 1'b1;
        req_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            tick(3'b000);
            chk("t4_stall_we", rf_we, 0);
        end
        stall = 1'b0;
        tick(3'b010);
        drain();

        // Saturating counter with a sole requester, no bubbles
        do_reset();
        a[2] = 5'd9; d[2] = 32'hCAFE_0002;
        req_valid = 3'b100;
        for (int c = 0; c < 20; c++) tick(3'b100);
        chk("t5_cnt_sat", grant_cnt, {4'd15, 4'd0, 4'd0});
        drain();
        chk("t5_cnt_hold", grant_cnt, {4'd15, 4'd0, 4'd0});

        // Reset mid-stream discards the pending grant and restores priority
        a[0] = 5'd4; a[1] = 5'd5; a[2] = 5'd6;
        d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
        req_valid = 3'b111;
        tick(3'b001);
        tick(3'b010);
        #1 chk("t6_ready_pre", req_ready, 3'b100);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_we_async", rf_we, 0);
        chk("t6_ready_rst", req_ready, 0);
        chk("t6_cnt_rst", grant_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(3'b001);
        tick(3'b010);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
